// File: rtl/hls_mem_pkg.sv
// Shared types and constants for the two-requester block-RAM arbiter.
// Default widths, requester id, read-return tag and the arbitration rule.
package hls_mem_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } rd_tag_t;

  localparam rd_tag_t TAG_IDLE = '{valid: 1'b0, id: REQ0};

  // A lone requester always wins; a tie goes to the favoured requester.
  function automatic req_id_t arb_pick(input logic ce0, input logic ce1, input req_id_t prio);
    if (ce0 && ce1) return prio;
    if (ce1) return REQ1;
    return REQ0;
  endfunction

endpackage

// File: rtl/hls_mem_arbiter_if.sv
// Kernel-side memory port (stall-by-grant) and the physical single-port RAM port.
// The arbiter is the slave of each kernel port and the master of the RAM port.
interface hls_mem_req_if
  import hls_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] d;
  logic              gnt;
  logic [DATA_W-1:0] q;
  logic              qvalid;

  modport master (output ce, we, address, d, input gnt, q, qvalid);
  modport slave  (input ce, we, address, d, output gnt, q, qvalid);
endinterface

interface hls_mem_ram_if
  import hls_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              ce;
  logic              we;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;

  modport master (output ce, we, address, d, input q);
  modport slave  (input ce, we, address, d, output q);
endinterface

// File: rtl/hls_rd_tag_pipe.sv
// Shift register of read-return tags, one stage per cycle between grant and ram_q.
// The last stage lines up with valid RAM read data.
module hls_rd_tag_pipe
  import hls_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    sys_clk,
  input  logic    sys_rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out,
  output logic    any_valid
);

  logic [DEPTH-1:0] valid_vec;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    rd_tag_t stage_reg;
    rd_tag_t stage_next;

    if (gi == 0) begin : g_head
      assign stage_next = tag_in;
    end else begin : g_tail
      assign stage_next = g_stage[gi-1].stage_reg;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        stage_reg <= TAG_IDLE;
      end else begin
        stage_reg <= stage_next;
      end
    end

    assign valid_vec[gi] = stage_reg.valid;
  end

  assign tag_out   = g_stage[DEPTH-1].stage_reg;
  assign any_valid = |valid_vec;

endmodule

// File: rtl/hls_mem_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between two HLS kernel ports.
// Grants are combinational; the winning access is registered onto the RAM port.
module hls_mem_arbiter
  import hls_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  hls_mem_req_if.slave  r0,
  hls_mem_req_if.slave  r1,
  hls_mem_ram_if.master ram,
  output logic          busy
);

  localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

  req_id_t           prio_reg;
  req_id_t           prio_next;
  req_id_t           winner;
  logic              grant;
  logic              win_we;
  logic [ADDR_W-1:0] win_address;
  logic [DATA_W-1:0] win_d;

  logic              ram_ce_reg;
  logic              ram_we_reg;
  logic [ADDR_W-1:0] ram_address_reg;
  logic [DATA_W-1:0] ram_d_reg;

  rd_tag_t           tag_in;
  rd_tag_t           tag_out;
  logic              tag_busy;

  always_comb begin
    grant       = r0.ce | r1.ce;
    winner      = arb_pick(r0.ce, r1.ce, prio_reg);
    win_we      = (winner == REQ1) ? r1.we : r0.we;
    win_address = (winner == REQ1) ? r1.address : r0.address;
    win_d       = (winner == REQ1) ? r1.d : r0.d;
    prio_next   = prio_reg;
    tag_in      = TAG_IDLE;
    if (grant) begin
      // Favour the other requester next time so a held request waits at most one cycle.
      prio_next = (winner == REQ0) ? REQ1 : REQ0;
      if (!win_we) begin
        tag_in = '{valid: 1'b1, id: winner};
      end
    end
  end

  assign r0.gnt = grant && (winner == REQ0);
  assign r1.gnt = grant && (winner == REQ1);

  // Address/data/we keep their last values on idle cycles; only ce drops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prio_reg        <= REQ0;
      ram_ce_reg      <= 1'b0;
      ram_we_reg      <= 1'b0;
      ram_address_reg <= '0;
      ram_d_reg       <= '0;
    end else begin
      prio_reg   <= prio_next;
      ram_ce_reg <= grant;
      if (grant) begin
        ram_we_reg      <= win_we;
        ram_address_reg <= win_address;
        ram_d_reg       <= win_d;
      end
    end
  end

  hls_rd_tag_pipe #(
    .DEPTH(LAT + 1)
  ) u_tag_pipe (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tag_in   (tag_in),
    .tag_out  (tag_out),
    .any_valid(tag_busy)
  );

  assign ram.ce      = ram_ce_reg;
  assign ram.we      = ram_we_reg;
  assign ram.address = ram_address_reg;
  assign ram.d       = ram_d_reg;

  assign r0.q      = ram.q;
  assign r1.q      = ram.q;
  assign r0.qvalid = tag_out.valid && (tag_out.id == REQ0);
  assign r1.qvalid = tag_out.valid && (tag_out.id == REQ1);

  assign busy = ram_ce_reg | tag_busy;

endmodule

// File: tb/tb_hls_mem_arbiter.sv
// Bench for hls_mem_arbiter: two DUTs (RD_LAT 1 and 3) share one stimulus stream and
// are checked every cycle against a grant-history model, plus directed literal checks.
module tb_hls_mem_arbiter;
  import hls_mem_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int NDUT = 2;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  logic [1:0]    r_ce;
  logic [1:0]    r_we;
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_d    [2];

  hls_mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r0_a ();
  hls_mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r1_a ();
  hls_mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r0_b ();
  hls_mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) r1_b ();
  hls_mem_ram_if #(.ADDR_W(AW), .DATA_W(DW)) ram_a ();
  hls_mem_ram_if #(.ADDR_W(AW), .DATA_W(DW)) ram_b ();

  assign r0_a.ce = r_ce[0]; assign r0_a.we = r_we[0]; assign r0_a.address = r_addr[0]; assign r0_a.d = r_d[0];
  assign r1_a.ce = r_ce[1]; assign r1_a.we = r_we[1]; assign r1_a.address = r_addr[1]; assign r1_a.d = r_d[1];
  assign r0_b.ce = r_ce[0]; assign r0_b.we = r_we[0]; assign r0_b.address = r_addr[0]; assign r0_b.d = r_d[0];
  assign r1_b.ce = r_ce[1]; assign r1_b.we = r_we[1]; assign r1_b.address = r_addr[1]; assign r1_b.d = r_d[1];

  logic [1:0]    g0_s, g1_s, qv0_s, qv1_s, rce_s, rwe_s, busy_s;
  logic [DW-1:0] q0_s [NDUT];
  logic [DW-1:0] q1_s [NDUT];
  logic [DW-1:0] rd_s [NDUT];
  logic [DW-1:0] rq_s [NDUT];
  logic [AW-1:0] ra_s [NDUT];

  assign g0_s  = {r0_b.gnt, r0_a.gnt};
  assign g1_s  = {r1_b.gnt, r1_a.gnt};
  assign qv0_s = {r0_b.qvalid, r0_a.qvalid};
  assign qv1_s = {r1_b.qvalid, r1_a.qvalid};
  assign rce_s = {ram_b.ce, ram_a.ce};
  assign rwe_s = {ram_b.we, ram_a.we};
  assign q0_s[0] = r0_a.q; assign q0_s[1] = r0_b.q;
  assign q1_s[0] = r1_a.q; assign q1_s[1] = r1_b.q;
  assign rd_s[0] = ram_a.d; assign rd_s[1] = ram_b.d;
  assign ra_s[0] = ram_a.address; assign ra_s[1] = ram_b.address;
  assign ram_a.q = rq_s[0];
  assign ram_b.q = rq_s[1];

  hls_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .r0(r0_a), .r1(r1_a), .ram(ram_a), .busy(busy_s[0])
  );
  hls_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .r0(r0_b), .r1(r1_b), .ram(ram_b), .busy(busy_s[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [DW-1:0] init_word(input int a);
    return (a == 5) ? 32'hA5A5_A5A5 : (32'hC0DE_0000 | DW'(a));
  endfunction

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", name, d, act, exp, $time);
    end
  endtask

  // 16-word RAM per DUT with a read pipeline of that DUT's latency; reloads on reset.
  for (genvar gi = 0; gi < NDUT; gi++) begin : g_ram
    localparam int L = (gi == 0) ? 1 : 3;
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] pipe [L];
    always @(posedge sys_clk) begin
      if (!sys_rst_n) begin
        for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
      end else if (rce_s[gi] && rwe_s[gi]) begin
        mem[ra_s[gi][3:0]] <= rd_s[gi];
      end
      pipe[0] <= mem[ra_s[gi][3:0]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign rq_s[gi] = pipe[L-1];
  end

  // Reference model: per-cycle grant history; read data is fixed at grant time.
  logic [1:0]    gm;
  logic [1:0]    exp_g;
  logic          prio_m;
  logic          w;
  int            cyc;
  logic          h_rd   [64];
  logic          h_id   [64];
  logic [DW-1:0] h_data [64];
  logic [DW-1:0] ref_mem [16];
  logic          e_ce, e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_d;
  logic [1:0]    exp_qv;
  logic [DW-1:0] exp_q;
  logic          exp_busy;
  logic [1:0]    p_ce, p_we;
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_d    [2];

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        chk("rst_ram_ce", d, 64'(rce_s[d]), 64'(0));
        chk("rst_ram_addr", d, 64'(ra_s[d]), 64'(0));
        chk("rst_busy", d, 64'(busy_s[d]), 64'(0));
        chk("rst_qvalid", d, 64'({qv1_s[d], qv0_s[d]}), 64'(0));
      end
      prio_m = 1'b0; cyc = 0; gm = 2'b00;
      e_ce = 1'b0; e_we = 1'b0; e_addr = '0; e_d = '0;
      p_ce = 2'b00;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (r_ce[k]) begin
          checks++;
          assert (!$isunknown({r_we[k], r_addr[k], r_d[k]}) &&
                  !(p_ce[k] && !gm[k] && {r_we[k], r_addr[k], r_d[k]} != {p_we[k], p_addr[k], p_d[k]}))
          else begin
            failures++;
            $display("FAIL protocol r%0d fields=%0h/%0h/%0h required stable %0h/%0h/%0h",
                     k, r_we[k], r_addr[k], r_d[k], p_we[k], p_addr[k], p_d[k]);
          end
        end
      end
      exp_g = (r_ce == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : r_ce;
      for (int d = 0; d < NDUT; d++) begin
        chk("gnt0", d, 64'(g0_s[d]), 64'(exp_g[0]));
        chk("gnt1", d, 64'(g1_s[d]), 64'(exp_g[1]));
        chk("ram_ce", d, 64'(rce_s[d]), 64'(e_ce));
        chk("ram_we", d, 64'(rwe_s[d]), 64'(e_we));
        chk("ram_address", d, 64'(ra_s[d]), 64'(e_addr));
        chk("ram_d", d, 64'(rd_s[d]), 64'(e_d));
        exp_qv = 2'b00; exp_q = '0;
        if (cyc - 1 - lat_of(d) >= 0 && h_rd[(cyc - 1 - lat_of(d)) % 64]) begin
          exp_qv[h_id[(cyc - 1 - lat_of(d)) % 64]] = 1'b1;
          exp_q = h_data[(cyc - 1 - lat_of(d)) % 64];
        end
        chk("qvalid0", d, 64'(qv0_s[d]), 64'(exp_qv[0]));
        chk("qvalid1", d, 64'(qv1_s[d]), 64'(exp_qv[1]));
        if (exp_qv[0]) chk("q0", d, 64'(q0_s[d]), 64'(exp_q));
        if (exp_qv[1]) chk("q1", d, 64'(q1_s[d]), 64'(exp_q));
        exp_busy = e_ce;
        for (int k = 1; k <= 1 + lat_of(d); k++) begin
          if (cyc - k >= 0 && h_rd[(cyc - k) % 64]) exp_busy = 1'b1;
        end
        chk("busy", d, 64'(busy_s[d]), 64'(exp_busy));
      end
      h_rd[cyc % 64] = 1'b0;
      e_ce = |exp_g;
      if (|exp_g) begin
        w = exp_g[1];
        e_we = r_we[w]; e_addr = r_addr[w]; e_d = r_d[w];
        if (r_we[w]) begin
          ref_mem[r_addr[w][3:0]] = r_d[w];
        end else begin
          h_rd[cyc % 64] = 1'b1;
          h_id[cyc % 64] = w;
          h_data[cyc % 64] = ref_mem[r_addr[w][3:0]];
        end
        prio_m = ~w;
      end
      gm = exp_g;
      p_ce = r_ce; p_we = r_we;
      p_addr[0] = r_addr[0]; p_addr[1] = r_addr[1];
      p_d[0] = r_d[0]; p_d[1] = r_d[1];
      cyc++;
    end
  end

  task automatic idle(input int n);
    r_ce = 2'b00;
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  initial begin
    r_ce = 2'b00; r_we = 2'b00;
    r_addr[0] = '0; r_addr[1] = '0; r_d[0] = '0; r_d[1] = '0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Both read every cycle from reset: strict alternation starting with r0.
    r_ce = 2'b11; r_addr[0] = 0; r_addr[1] = 8;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("alt_gnt0", 0, 64'(g0_s[0]), 64'((i % 2) == 0));
      chk("alt_gnt1", 0, 64'(g1_s[0]), 64'((i % 2) == 1));
      @(posedge sys_clk); #1;
      if (gm[0]) r_addr[0] = r_addr[0] + 1;
      if (gm[1]) r_addr[1] = r_addr[1] + 1;
    end
    idle(6);

    // r1 granted alone, then a tie goes to r0, then held r1 follows.
    r_ce = 2'b10; r_we = 2'b00; r_addr[1] = 3;
    @(negedge sys_clk); chk("solo_gnt1", 0, 64'(g1_s[0]), 64'(1));
    @(posedge sys_clk); #1; r_ce = 2'b11; r_addr[0] = 4; r_addr[1] = 6;
    @(negedge sys_clk); chk("tie_gnt0", 0, 64'(g0_s[0]), 64'(1)); chk("tie_gnt1", 0, 64'(g1_s[0]), 64'(0));
    @(posedge sys_clk); #1; r_ce = 2'b10;
    @(negedge sys_clk); chk("held_gnt1", 0, 64'(g1_s[0]), 64'(1));
    @(posedge sys_clk); #1;
    idle(6);

    // r0 reads address 5.
    r_ce = 2'b01; r_we = 2'b00; r_addr[0] = 5;
    @(negedge sys_clk); chk("rd5_gnt0", 0, 64'(g0_s[0]), 64'(1)); chk("rd5_gnt1", 0, 64'(g1_s[0]), 64'(0));
    @(posedge sys_clk); #1; r_ce = 2'b00;
    @(negedge sys_clk); chk("rd5_ram_ce", 0, 64'(rce_s[0]), 64'(1)); chk("rd5_ram_addr", 0, 64'(ra_s[0]), 64'(5));
    @(negedge sys_clk); chk("rd5_qv0", 0, 64'(qv0_s[0]), 64'(1)); chk("rd5_q0", 0, 64'(q0_s[0]), 64'(32'hA5A5_A5A5));
    chk("rd5_qv1", 0, 64'(qv1_s[0]), 64'(0));
    @(negedge sys_clk); chk("rd5_lat3_early", 1, 64'(qv0_s[1]), 64'(0));
    @(negedge sys_clk); chk("rd5_lat3_qv0", 1, 64'(qv0_s[1]), 64'(1)); chk("rd5_lat3_q0", 1, 64'(q0_s[1]), 64'(32'hA5A5_A5A5));
    @(posedge sys_clk); #1;
    idle(4);

    // r1 writes 0x1234 to address 7, r0 reads it back next cycle.
    r_ce = 2'b10; r_we = 2'b10; r_addr[1] = 7; r_d[1] = 32'h1234;
    @(negedge sys_clk); chk("wr7_gnt1", 0, 64'(g1_s[0]), 64'(1));
    @(posedge sys_clk); #1; r_ce = 2'b01; r_we = 2'b00; r_addr[0] = 7;
    @(negedge sys_clk); chk("rd7_gnt0", 0, 64'(g0_s[0]), 64'(1));
    @(posedge sys_clk); #1; r_ce = 2'b00;
    @(negedge sys_clk); chk("wr7_no_qv", 0, 64'({qv1_s[0], qv0_s[0]}), 64'(0));
    @(negedge sys_clk); chk("rd7_qv0", 0, 64'(qv0_s[0]), 64'(1)); chk("rd7_q0", 0, 64'(q0_s[0]), 64'(32'h1234));
    @(posedge sys_clk); #1;
    idle(6);

    // Randomised traffic: hold until granted, occasional drops, mixed reads/writes.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (r_ce[k] && gm[k]) r_ce[k] = 1'b0;
        if (r_ce[k] && $urandom_range(15) == 0) begin
          r_ce[k] = 1'b0;
        end else if (!r_ce[k] && $urandom_range(3) != 0) begin
          r_ce[k]   = 1'b1;
          r_we[k]   = ($urandom_range(2) == 0);
          r_addr[k] = AW'($urandom_range(15));
          r_d[k]    = $urandom;
        end
      end
      @(posedge sys_clk); #1;
    end
    idle(8);

    // Two reads granted, then a one-cycle reset pulse discards them.
    r_ce = 2'b11; r_we = 2'b00; r_addr[0] = 2; r_addr[1] = 9;
    @(negedge sys_clk);
    @(posedge sys_clk); #1; r_ce = r_ce & ~gm;
    @(negedge sys_clk);
    @(posedge sys_clk); #1; r_ce = 2'b00; sys_rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("arst_ram_ce", d, 64'(rce_s[d]), 64'(0));
      chk("arst_ram_addr", d, 64'(ra_s[d]), 64'(0));
      chk("arst_busy", d, 64'(busy_s[d]), 64'(0));
      chk("arst_qvalid", d, 64'({qv1_s[d], qv0_s[d]}), 64'(0));
    end
    @(posedge sys_clk); #1; sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      chk("post_rst_qv_a", 0, 64'({qv1_s[0], qv0_s[0]}), 64'(0));
      chk("post_rst_qv_b", 1, 64'({qv1_s[1], qv0_s[1]}), 64'(0));
    end
    @(posedge sys_clk); #1; r_ce = 2'b11;
    @(negedge sys_clk); chk("post_rst_prio_gnt0", 0, 64'(g0_s[0]), 64'(1)); chk("post_rst_prio_gnt1", 0, 64'(g1_s[0]), 64'(0));
    @(posedge sys_clk); #1;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout reached required=finish");
    $fatal(1, "watchdog");
  end

endmodule
